// File: rtl/win_avg_out_buf_if.sv
// win_avg_out_buf_if: upstream sample strobe plus downstream valid/ready handshake
interface win_avg_out_buf_if #(
  parameter int SUM_W = 11,
  parameter int OUT_W = 8
);
  logic [SUM_W-1:0] i_sum;
  logic             i_en;
  logic [OUT_W-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  modport master (output i_sum, i_en, i_ready, input o_data, o_valid);
  modport slave  (input i_sum, i_en, i_ready, output o_data, o_valid);
endinterface

// File: rtl/win_avg_out_buf.sv
// win_avg_out_buf: warm-up discard, rounded/saturated window average, FWFT FIFO with sticky overflow
module win_avg_out_buf #(
  parameter int SUM_W    = 11,
  parameter int WIN      = 8,
  parameter int LOG2_WIN = 3,
  parameter int OUT_W    = 8,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  win_avg_out_buf_if.slave         bus,
  output logic                     o_ovf,
  input  logic                     i_clr_ovf,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIN + 1);
  localparam logic [SUM_W:0] HALF = (SUM_W + 1)'(WIN / 2);
  localparam logic [SUM_W:0] MAXV = (SUM_W + 1)'(2 ** OUT_W - 1);
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic             s_vld_q, s_vld_d;
  logic [OUT_W-1:0] s_avg_q, s_avg_d;
  logic [OUT_W-1:0] last_q, last_d;
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic             warm, empty, full, pop, push;
  logic [SUM_W:0]   rnd, avg;
  // Next-state: warm-up counting, rounding stage, pointer moves and overflow flag
  always_comb begin
    warm    = wcnt_q == CW'(WIN);
    rnd     = {1'b0, bus.i_sum} + HALF;
    avg     = rnd >> LOG2_WIN;
    empty   = wr_q == rd_q;
    full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    pop     = !empty && bus.i_ready;
    push    = s_vld_q && (!full || pop);
    wcnt_d  = (bus.i_en && !warm) ? wcnt_q + 1'b1 : wcnt_q;
    s_vld_d = bus.i_en && warm;
    s_avg_d = s_vld_d ? ((avg > MAXV) ? '1 : avg[OUT_W-1:0]) : s_avg_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    last_d  = pop ? mem_q[rd_q[AW-1:0]] : last_q;
    ovf_d   = (s_vld_q && full && !pop) ? 1'b1 : i_clr_ovf ? 1'b0 : ovf_q;
  end
  // Control state with asynchronous flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      s_vld_q <= 1'b0;
      s_avg_q <= '0;
      last_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      s_vld_q <= s_vld_d;
      s_avg_q <= s_avg_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end
  // Storage needs no reset: it is only visible through the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= s_avg_q;
  end
  assign bus.o_valid = !empty;
  assign bus.o_data  = empty ? last_q : mem_q[rd_q[AW-1:0]];
  assign o_level     = wr_q - rd_q;
  assign o_ovf       = ovf_q;
endmodule

// File: tb/tb_win_avg_out_buf.sv
// tb_win_avg_out_buf: randomized and directed checks against a queue-based reference model
module tb_win_avg_out_buf;
  localparam int WIN = 8, DEPTH = 4;
  logic clk = 0, rst_n = 1, clr_ovf = 0, ovf, ovf12, clr12 = 0;
  logic [2:0] level, level12;
  int errors = 0, checks = 0;
  int m_cnt, m_sval, m_last, q[$];
  bit m_sv, m_ovf;
  logic e_valid, e_ovf;
  logic [7:0] e_data;
  logic [2:0] e_level;

  win_avg_out_buf_if #(.SUM_W(11), .OUT_W(8)) bus ();
  win_avg_out_buf_if #(.SUM_W(12), .OUT_W(8)) bus12 ();

  win_avg_out_buf #(.SUM_W(11), .WIN(8), .LOG2_WIN(3), .OUT_W(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .o_ovf(ovf), .i_clr_ovf(clr_ovf), .o_level(level));
  win_avg_out_buf #(.SUM_W(12), .WIN(8), .LOG2_WIN(3), .OUT_W(8), .DEPTH(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12.slave), .o_ovf(ovf12), .i_clr_ovf(clr12), .o_level(level12));

  always #5 clk = ~clk;

  function automatic int ref_avg(int s);
    int a;
    a = (s + WIN / 2) / WIN;
    return (a > 255) ? 255 : a;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sv = 0; m_sval = 0; m_last = 0; m_ovf = 0; q.delete();
    e_valid = 0; e_data = 0; e_level = 0; e_ovf = 0;
  endtask

  task automatic step();
    bit pop, drop;
    @(posedge clk);
    pop = q.size() > 0 && bus.i_ready;
    drop = 0;
    if (pop) m_last = q.pop_front();
    if (m_sv) begin
      if (q.size() < DEPTH) q.push_back(m_sval);
      else drop = 1;
    end
    m_ovf = drop ? 1 : clr_ovf ? 0 : m_ovf;
    m_sv = bus.i_en && m_cnt >= WIN;
    m_sval = ref_avg(int'(bus.i_sum));
    if (bus.i_en && m_cnt < WIN) m_cnt++;
    e_valid = q.size() > 0;
    e_data = 8'((q.size() > 0) ? q[0] : m_last);
    e_level = 3'(q.size());
    e_ovf = m_ovf;
    #1;
  endtask

  task automatic drive(input bit en, input bit rdy, input int s, input bit clr);
    bus.i_en = en; bus.i_ready = rdy; bus.i_sum = 11'(s); clr_ovf = clr;
  endtask

  task automatic drain();
    drive(0, 1, 0, 1);
    repeat (DEPTH + 2) step();
    clr_ovf = 0;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1, 1, 100, 0);
    bus12.i_en = 1; bus12.i_ready = 1; bus12.i_sum = 12'd4095;
    #1 rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    if ({bus.o_valid, bus.o_data, level, ovf} !== 12'h0) begin
      errors++;
      $display("FAIL reset: v=%b d=%0d l=%0d o=%b want all zero", bus.o_valid, bus.o_data, level, ovf);
    end
    checks++;
    #6 rst_n = 1;
  endtask

  task automatic test_warmup();
    for (int i = 1; i <= 12; i++) begin
      step();
      if ({bus.o_valid, bus.o_data, level, ovf} !== {e_valid, e_data, e_level, e_ovf}) begin
        errors++;
        $display("FAIL warmup cyc%0d: v=%b d=%0d l=%0d o=%b want v=%b d=%0d l=%0d o=%b", i,
                 bus.o_valid, bus.o_data, level, ovf, e_valid, e_data, e_level, e_ovf);
      end
      checks++;
      if (i == 9 || i == 10) begin
        if (bus.o_valid !== (i == 10) || (i == 10 && bus.o_data !== 8'd13)) begin
          errors++;
          $display("FAIL warmup_first cyc%0d: v=%b d=%0d want v=%b d=13", i, bus.o_valid, bus.o_data, i == 10);
        end
        checks++;
      end
    end
  endtask

  task automatic test_rounding();
    int sums[5] = '{2040, 1019, 1020, 3, 4};
    int outs[5] = '{255, 127, 128, 0, 1};
    drain();
    foreach (sums[i]) begin
      drive(1, 1, sums[i], 0);
      step();
      drive(0, 1, 0, 0);
      step();
      if (bus.o_valid !== 1'b1 || bus.o_data !== 8'(outs[i]) || e_data !== 8'(outs[i])) begin
        errors++;
        $display("FAIL round sum=%0d: v=%b d=%0d model=%0d want %0d", sums[i], bus.o_valid, bus.o_data, e_data, outs[i]);
      end
      checks++;
      step();
    end
  endtask

  task automatic test_random();
    drain();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)),
            $urandom_range(0, 7) == 0);
      step();
      if ({bus.o_valid, bus.o_data, level, ovf} !== {e_valid, e_data, e_level, e_ovf}) begin
        errors++;
        $display("FAIL random cyc%0d: v=%b d=%0d l=%0d o=%b want v=%b d=%0d l=%0d o=%b", i,
                 bus.o_valid, bus.o_data, level, ovf, e_valid, e_data, e_level, e_ovf);
      end
      checks++;
    end
  endtask

  task automatic test_backpressure();
    drain();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 8 * i, 0);
      step();
      if ({bus.o_valid, bus.o_data, level, ovf} !== {e_valid, e_data, e_level, e_ovf}) begin
        errors++;
        $display("FAIL backpressure cyc%0d: v=%b d=%0d l=%0d o=%b want v=%b d=%0d l=%0d o=%b", i,
                 bus.o_valid, bus.o_data, level, ovf, e_valid, e_data, e_level, e_ovf);
      end
      checks++;
      if ((i == 5 && ovf !== 1'b0) || (i == 6 && ovf !== 1'b1)) begin
        errors++;
        $display("FAIL ovf_timing cyc%0d: ovf=%b want %b", i, ovf, i == 6);
      end
      if (i == 5 || i == 6) checks++;
    end
    if (level !== 3'd4 || bus.o_data !== 8'd1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: l=%0d d=%0d o=%b want l=4 d=1 o=1", level, bus.o_data, ovf);
    end
    checks++;
    drive(0, 0, 0, 0);
    step();
    drive(0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      if (bus.o_data !== 8'(k)) begin
        errors++;
        $display("FAIL drain_data %0d: d=%0d want %0d", k, bus.o_data, k);
      end
      checks++;
      step();
      if (level !== 3'(4 - k) || level !== e_level) begin
        errors++;
        $display("FAIL drain_level %0d: l=%0d want %0d", k, level, 4 - k);
      end
      checks++;
    end
  endtask

  task automatic test_push_pop_full();
    drain();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 8 * i, 0);
      step();
    end
    drive(0, 1, 0, 0);
    step();
    if (level !== 3'd4 || ovf !== 1'b0 || bus.o_data !== 8'd2) begin
      errors++;
      $display("FAIL push_pop_full: l=%0d o=%b d=%0d want l=4 o=0 d=2", level, ovf, bus.o_data);
    end
    checks++;
    for (int k = 0; k < 5; k++) begin
      step();
      if ({bus.o_valid, bus.o_data, level, ovf} !== {e_valid, e_data, e_level, e_ovf}) begin
        errors++;
        $display("FAIL push_pop_drain %0d: v=%b d=%0d l=%0d o=%b want v=%b d=%0d l=%0d o=%b", k,
                 bus.o_valid, bus.o_data, level, ovf, e_valid, e_data, e_level, e_ovf);
      end
      checks++;
    end
  endtask

  task automatic test_ovf_clear();
    drain();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 8 * i, 0);
      step();
    end
    drive(0, 0, 0, 1);
    step();
    if (ovf !== 1'b1 || e_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: o=%b model=%b want 1", ovf, e_ovf);
    end
    checks++;
    step();
    if (ovf !== 1'b0 || e_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: o=%b model=%b want 0", ovf, e_ovf);
    end
    checks++;
    clr_ovf = 0;
  endtask

  task automatic test_reset_mid();
    drain();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 8 * i, 0);
      step();
    end
    drive(0, 0, 0, 0);
    step();
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_level: l=%0d want 3", level);
    end
    checks++;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    if (bus.o_valid !== 1'b0 || level !== 3'd0 || bus.o_data !== 8'd0) begin
      errors++;
      $display("FAIL async_flush: v=%b l=%0d d=%0d want 0 0 0", bus.o_valid, level, bus.o_data);
    end
    checks++;
    model_reset();
    #1 rst_n = 1;
    drive(1, 1, 200, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      if ({bus.o_valid, bus.o_data, level, ovf} !== {e_valid, e_data, e_level, e_ovf}) begin
        errors++;
        $display("FAIL rewarm cyc%0d: v=%b d=%0d l=%0d o=%b want v=%b d=%0d l=%0d o=%b", i,
                 bus.o_valid, bus.o_data, level, ovf, e_valid, e_data, e_level, e_ovf);
      end
      checks++;
      if ((i == 9 && bus.o_valid !== 1'b0) || (i == 10 && (bus.o_valid !== 1'b1 || bus.o_data !== 8'd25))) begin
        errors++;
        $display("FAIL rewarm_first cyc%0d: v=%b d=%0d", i, bus.o_valid, bus.o_data);
      end
      if (i == 9 || i == 10) checks++;
    end
  endtask

  task automatic test_sum12();
    if (bus12.o_valid !== 1'b1 || bus12.o_data !== 8'd255) begin
      errors++;
      $display("FAIL sat_sum12: v=%b d=%0d want v=1 d=255", bus12.o_valid, bus12.o_data);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_rounding();
    test_random();
    test_backpressure();
    test_push_pop_full();
    test_ovf_clear();
    test_reset_mid();
    test_sum12();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/win_avg_out_buf.md
Name: win_avg_out_buf

Overview:
- Downstream stage of the 8-tap window-sum block (i_data[7:0] in, o_y[10:0] out).
- Takes the running window sum each clock and discards the warm-up outputs.
- Converts each sum to a rounded 8-bit average.
- Buffers averages in a small first-word-fall-through FIFO with a valid/ready handshake toward the consumer, plus a sticky overflow flag.

Parameters:
- SUM_W, 11, width of incoming window sum
- WIN, 8, window length of upstream sum; power of two, ≥2
- LOG2_WIN, 3, log2(WIN)
- OUT_W, 8, width of averaged output
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_sum  input  SUM_W  window sum from upstream (o_y)
- i_en  input  1  sample strobe; i_sum sampled when high
- o_data  output  OUT_W  FIFO head (averaged sample)
- o_valid  output  1  o_data valid (FIFO not empty)
- i_ready  input  1  consumer accepts o_data this cycle
- o_ovf  output  1  sticky: a sample was dropped because the FIFO was full
- i_clr_ovf  input  1  synchronous clear of o_ovf
- o_level  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: o_valid=0, o_data=0, o_ovf=0, o_level=0. FIFO pointers, warm-up counter and stage register are cleared.
- Reset asserted mid-operation flushes all buffered data immediately; warm-up restarts.
- Warm-up:
  - Counter wcnt counts accepted samples (i_en=1) from 0 and saturates at WIN.
  - While wcnt<WIN the sample is discarded: no FIFO write, no overflow.
  - The first WIN accepted samples after reset are therefore dropped. The (WIN+1)th accepted sample is the first one processed.
- Arithmetic, stage 1 (registered at the edge where i_en=1 and warm-up is complete):
  - avg = (i_sum + WIN/2) >> LOG2_WIN, computed at SUM_W+1 bits, so the rounding add cannot overflow. Round half up.
  - If avg > 2^OUT_W−1, saturate to 2^OUT_W−1.
  - A 1-bit stage-valid flag s_vld accompanies the result.
- FIFO write: at the next edge, if s_vld=1.
  - If the FIFO is full and no pop occurs that cycle, the entry is dropped and o_ovf is set to 1.
  - If full and a pop occurs the same cycle, the write is accepted and o_level stays DEPTH.
- FIFO read:
  - Pop occurs when o_valid && i_ready.
  - o_data always shows the head entry (fall-through). o_data is held stable while o_valid && !i_ready.
  - When empty, o_valid=0 and o_data holds its last value (0 after reset).
- Latency: sample accepted at edge k appears on o_data/o_valid after edge k+1 when the FIFO was empty. That is 2 cycles from i_sum presentation to visibility.
- Empty-FIFO push with same-cycle ready: no bypass. Data becomes visible one cycle after the write.
- Simultaneous push and pop at any level: o_level unchanged.
- Pointer wrap: log2(DEPTH)-bit addresses plus an extra wrap bit. Full = addresses equal and wrap bits differ.
- o_ovf:
  - Set takes priority over i_clr_ovf when both occur in the same cycle.
  - Otherwise i_clr_ovf=1 clears o_ovf at the next edge.
- i_en=0: no sample consumed, stage holds s_vld=0, warm-up counter frozen.

Test Plan:
- Warm-up discard: rst_n low until 22 ns, i_en=1, i_ready=1, i_sum=100 constant → first 8 samples discarded. 9th produces o_data=13 ((100+4)>>3) with o_valid high 2 cycles after sampling.
- Rounding and saturation:
  - i_sum=2040 → 255.
  - i_sum=1019 → 127 ((1019+4)>>3).
  - i_sum=1020 → 128.
  - i_sum=3 → 0.
  - i_sum=4 → 1.
  - Rerun with SUM_W=12, i_sum=4095 → saturated 255.
- Backpressure/full: after warm-up, i_ready=0 for 10 sampling cycles with i_sum=8,16,24,… → o_level reaches 4, o_data holds 1, o_ovf=1 after 5th write attempt. Then i_ready=1 → o_data sequence 1,2,3,4, o_level 4→0.
- Push+pop at full: FIFO full, i_ready=1 and s_vld=1 same cycle → o_level stays 4, o_ovf unchanged, no data lost.
- Overflow clear race: i_clr_ovf=1 in the same cycle as a drop → o_ovf stays 1. i_clr_ovf=1 alone → o_ovf=0 next cycle.
- Reset mid-stream: rst_n pulsed low asynchronously (between edges) with 3 entries buffered → o_valid=0, o_level=0 immediately. After release, 8 samples are discarded again before output resumes.
